// File: rtl/up_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// up_arbiter_2to1
//
// Purpose:
//   Shares one uP register-bus slave between two requesters (s0, s1).
//   The read and write channels are arbitrated independently. Each channel
//   runs a small IDLE -> REQ -> DONE sequencer with round-robin tie-breaking
//   and a watchdog that forces completion if the slave never acknowledges.
//
// Parameters:
//   ADDRESS_WIDTH  : uP address width
//   BUS_WIDTH      : data width in bytes
//   TIMEOUT_CYCLES : cycles spent in REQ before forced completion (0 = never)
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   sN_up_rreq/raddr         : read request/address from requester N
//   sN_up_rack/rdata         : read acknowledge/data back to requester N
//   sN_up_wreq/waddr/wdata   : write request/address/data from requester N
//   sN_up_wack               : write acknowledge back to requester N
//   m_up_rreq/raddr          : read request/address to the slave
//   m_up_rack/rdata          : read acknowledge/data from the slave
//   m_up_wreq/waddr/wdata    : write request/address/data to the slave
//   m_up_wack                : write acknowledge from the slave
//   timeout                  : one-cycle pulse when a watchdog fires
// -----------------------------------------------------------------------------
module up_arbiter_2to1 #(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int BUS_WIDTH      = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                       clk,
   input  logic                       rst,

   input  logic                       s0_up_rreq,
   input  logic [ADDRESS_WIDTH-1:0]   s0_up_raddr,
   output logic                       s0_up_rack,
   output logic [BUS_WIDTH*8-1:0]     s0_up_rdata,
   input  logic                       s0_up_wreq,
   input  logic [ADDRESS_WIDTH-1:0]   s0_up_waddr,
   input  logic [BUS_WIDTH*8-1:0]     s0_up_wdata,
   output logic                       s0_up_wack,

   input  logic                       s1_up_rreq,
   input  logic [ADDRESS_WIDTH-1:0]   s1_up_raddr,
   output logic                       s1_up_rack,
   output logic [BUS_WIDTH*8-1:0]     s1_up_rdata,
   input  logic                       s1_up_wreq,
   input  logic [ADDRESS_WIDTH-1:0]   s1_up_waddr,
   input  logic [BUS_WIDTH*8-1:0]     s1_up_wdata,
   output logic                       s1_up_wack,

   output logic                       m_up_rreq,
   output logic [ADDRESS_WIDTH-1:0]   m_up_raddr,
   input  logic                       m_up_rack,
   input  logic [BUS_WIDTH*8-1:0]     m_up_rdata,
   output logic                       m_up_wreq,
   output logic [ADDRESS_WIDTH-1:0]   m_up_waddr,
   output logic [BUS_WIDTH*8-1:0]     m_up_wdata,
   input  logic                       m_up_wack,

   output logic                       timeout
);

   localparam int DATA_W = BUS_WIDTH * 8;

   // The counter only has to reach TIMEOUT_CYCLES-1.
   localparam int               CNT_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam bit               WATCHDOG_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Channel index 0 = read, 1 = write.
   logic [1:0] ch_req [2];
   logic [1:0] ch_ack [2];
   logic [1:0] ch_mack;
   logic [1:0] ch_mreq;
   logic [1:0] ch_load;
   logic [1:0] ch_sel;
   logic [1:0] ch_expired;

   assign ch_req[0] = {s1_up_rreq, s0_up_rreq};
   assign ch_req[1] = {s1_up_wreq, s0_up_wreq};
   assign ch_mack   = {m_up_wack, m_up_rack};

   // -------------------------------------------------------------------------
   // Per-channel sequencer. last_reg doubles as the owner of the transaction
   // in flight: it is updated on every grant and only read for routing in DONE.
   // -------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         state_t           state_reg,   state_next;
         logic             last_reg,    last_next;
         logic [CNT_W-1:0] cnt_reg,     cnt_next;
         logic             expired_reg, expired_next;
         logic             load;
         logic             sel;

         always_ff @(posedge clk) begin
            if (rst) begin
               state_reg   <= IDLE;
               last_reg    <= 1'b1;   // requester 0 wins the first tie
               cnt_reg     <= '0;
               expired_reg <= 1'b0;
            end else begin
               state_reg   <= state_next;
               last_reg    <= last_next;
               cnt_reg     <= cnt_next;
               expired_reg <= expired_next;
            end
         end

         always_comb begin
            state_next   = state_reg;
            last_next    = last_reg;
            cnt_next     = cnt_reg;
            expired_next = expired_reg;
            load         = 1'b0;
            sel          = last_reg;

            case (state_reg)
               IDLE: begin
                  if (ch_req[gi] != 2'b00) begin
                     // Tie goes to whoever was not served last.
                     sel          = (ch_req[gi] == 2'b11) ? ~last_reg : ch_req[gi][1];
                     load         = 1'b1;
                     last_next    = sel;
                     cnt_next     = '0;
                     expired_next = 1'b0;
                     state_next   = REQ;
                  end
               end
               REQ: begin
                  cnt_next = cnt_reg + CNT_W'(1);
                  // A real acknowledge wins over a watchdog expiry in the same cycle.
                  if (ch_mack[gi]) begin
                     state_next = DONE;
                  end else if (WATCHDOG_EN && (cnt_reg == CNT_LAST)) begin
                     expired_next = 1'b1;
                     state_next   = DONE;
                  end
               end
               DONE: begin
                  state_next = IDLE;
               end
               default: begin
                  state_next = IDLE;
               end
            endcase
         end

         assign ch_mreq[gi]    = (state_reg == REQ);
         assign ch_ack[gi]     = {(state_reg == DONE) &&  last_reg,
                                  (state_reg == DONE) && !last_reg};
         assign ch_expired[gi] = (state_reg == DONE) && expired_reg;
         assign ch_load[gi]    = load;
         assign ch_sel[gi]     = sel;
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Datapath: slave-side address/data registers and captured read data.
   // The captured read data is cleared on grant so a watchdog completion
   // returns zero rather than a stale value.
   // -------------------------------------------------------------------------
   logic [ADDRESS_WIDTH-1:0] raddr_reg;
   logic [ADDRESS_WIDTH-1:0] waddr_reg;
   logic [DATA_W-1:0]        wdata_reg;
   logic [DATA_W-1:0]        rdata_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         raddr_reg <= '0;
         waddr_reg <= '0;
         wdata_reg <= '0;
         rdata_reg <= '0;
      end else begin
         if (ch_load[0]) begin
            raddr_reg <= ch_sel[0] ? s1_up_raddr : s0_up_raddr;
            rdata_reg <= '0;
         end else if (ch_mreq[0] && m_up_rack) begin
            rdata_reg <= m_up_rdata;
         end

         if (ch_load[1]) begin
            waddr_reg <= ch_sel[1] ? s1_up_waddr : s0_up_waddr;
            wdata_reg <= ch_sel[1] ? s1_up_wdata : s0_up_wdata;
         end
      end
   end

   assign m_up_rreq   = ch_mreq[0];
   assign m_up_raddr  = raddr_reg;
   assign m_up_wreq   = ch_mreq[1];
   assign m_up_waddr  = waddr_reg;
   assign m_up_wdata  = wdata_reg;

   assign s0_up_rack  = ch_ack[0][0];
   assign s1_up_rack  = ch_ack[0][1];
   assign s0_up_wack  = ch_ack[1][0];
   assign s1_up_wack  = ch_ack[1][1];

   // Read data is only presented to the requester currently being acknowledged.
   assign s0_up_rdata = ch_ack[0][0] ? rdata_reg : '0;
   assign s1_up_rdata = ch_ack[0][1] ? rdata_reg : '0;

   // Simultaneous expiry on both channels still forms a single pulse.
   assign timeout     = |ch_expired;

endmodule

// File: tb/tb_up_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// tb_up_arbiter_2to1
//
// Directed testbench for up_arbiter_2to1 with a short watchdog
// (TIMEOUT_CYCLES = 8). The slave side is driven directly from each test
// task. Inputs change and outputs are sampled 1 time unit after the rising
// edge; "cycle N" below means the interval after the Nth edge following the
// cycle in which the request was first presented (cycle 0).
// -----------------------------------------------------------------------------
module tb_up_arbiter_2to1;

   localparam int AW     = 32;
   localparam int BW     = 4;
   localparam int DW     = BW * 8;
   localparam int TO     = 8;
   localparam int OUTS_W = 2*AW + 3*DW + 7;

   logic          clk;
   logic          rst;
   logic          s0_up_rreq, s1_up_rreq, s0_up_wreq, s1_up_wreq;
   logic [AW-1:0] s0_up_raddr, s1_up_raddr, s0_up_waddr, s1_up_waddr;
   logic [DW-1:0] s0_up_wdata, s1_up_wdata;
   logic          s0_up_rack, s1_up_rack, s0_up_wack, s1_up_wack;
   logic [DW-1:0] s0_up_rdata, s1_up_rdata;
   logic          m_up_rreq, m_up_wreq, m_up_rack, m_up_wack;
   logic [AW-1:0] m_up_raddr, m_up_waddr;
   logic [DW-1:0] m_up_wdata, m_up_rdata;
   logic          timeout;

   int checks = 0;
   int errors = 0;

   logic [OUTS_W-1:0] outs;
   assign outs = {m_up_rreq, m_up_raddr, m_up_wreq, m_up_waddr, m_up_wdata,
                  s0_up_rack, s0_up_rdata, s0_up_wack,
                  s1_up_rack, s1_up_rdata, s1_up_wack, timeout};

   up_arbiter_2to1 #(
      .ADDRESS_WIDTH (AW),
      .BUS_WIDTH     (BW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s0_up_rreq (s0_up_rreq),
      .s0_up_raddr(s0_up_raddr),
      .s0_up_rack (s0_up_rack),
      .s0_up_rdata(s0_up_rdata),
      .s0_up_wreq (s0_up_wreq),
      .s0_up_waddr(s0_up_waddr),
      .s0_up_wdata(s0_up_wdata),
      .s0_up_wack (s0_up_wack),
      .s1_up_rreq (s1_up_rreq),
      .s1_up_raddr(s1_up_raddr),
      .s1_up_rack (s1_up_rack),
      .s1_up_rdata(s1_up_rdata),
      .s1_up_wreq (s1_up_wreq),
      .s1_up_waddr(s1_up_waddr),
      .s1_up_wdata(s1_up_wdata),
      .s1_up_wack (s1_up_wack),
      .m_up_rreq  (m_up_rreq),
      .m_up_raddr (m_up_raddr),
      .m_up_rack  (m_up_rack),
      .m_up_rdata (m_up_rdata),
      .m_up_wreq  (m_up_wreq),
      .m_up_waddr (m_up_waddr),
      .m_up_wdata (m_up_wdata),
      .m_up_wack  (m_up_wack),
      .timeout    (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      s0_up_rreq = 1'b1;   // requests during reset must not leak through
      s1_up_wreq = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (outs !== '0) begin
         $display("FAIL reset_outputs: got %h want 0", outs);
         errors++;
      end
      rst = 1'b0;
      s0_up_rreq = 1'b0;
      s1_up_wreq = 1'b0;
      tick();
      checks++;
      if (outs !== '0) begin
         $display("FAIL reset_idle: got %h want 0", outs);
         errors++;
      end
      $display("txn reset done");
   endtask

   // -------------------------------------------------------------------------
   task automatic test_tie();
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_data;
      logic          exp_s1;
      s0_up_waddr = 32'h0; s0_up_wdata = 32'h1; s0_up_wreq = 1'b1;
      s1_up_waddr = 32'h8; s1_up_wdata = 32'h2; s1_up_wreq = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_s1   = (i % 2) == 1;
         exp_addr = exp_s1 ? 32'h8 : 32'h0;
         exp_data = exp_s1 ? 32'h2 : 32'h1;
         tick();                                  // cycle 1: REQ
         checks++;
         if ({m_up_wreq, m_up_waddr, m_up_wdata} !== {1'b1, exp_addr, exp_data}) begin
            $display("FAIL tie_grant%0d: got wreq=%b addr=%h data=%h want wreq=1 addr=%h data=%h",
                     i, m_up_wreq, m_up_waddr, m_up_wdata, exp_addr, exp_data);
            errors++;
         end
         m_up_wack = 1'b1;
         tick();                                  // cycle 2: DONE
         m_up_wack = 1'b0;
         checks++;
         if ({m_up_wreq, s0_up_wack, s1_up_wack} !== {1'b0, !exp_s1, exp_s1}) begin
            $display("FAIL tie_ack%0d: got wreq=%b wack0=%b wack1=%b want wreq=0 wack0=%b wack1=%b",
                     i, m_up_wreq, s0_up_wack, s1_up_wack, !exp_s1, exp_s1);
            errors++;
         end
         if (i == 3) begin
            s0_up_wreq = 1'b0;
            s1_up_wreq = 1'b0;
         end
         tick();                                  // cycle 3: IDLE
         checks++;
         if ({m_up_wreq, s0_up_wack, s1_up_wack} !== 3'b000) begin
            $display("FAIL tie_gap%0d: got wreq=%b wack0=%b wack1=%b want 000",
                     i, m_up_wreq, s0_up_wack, s1_up_wack);
            errors++;
         end
         $display("txn tie write %0d addr=%h", i, exp_addr);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_single_read();
      s0_up_raddr = 32'h4;
      s0_up_rreq  = 1'b1;
      tick();                                     // cycle 1
      checks++;
      if ({m_up_rreq, m_up_raddr, s0_up_rack} !== {1'b1, 32'h4, 1'b0}) begin
         $display("FAIL read_req: got rreq=%b addr=%h rack0=%b want 1 00000004 0",
                  m_up_rreq, m_up_raddr, s0_up_rack);
         errors++;
      end
      m_up_rack  = 1'b1;
      m_up_rdata = 32'hA5A5_0001;
      tick();                                     // cycle 2
      m_up_rack  = 1'b0;
      m_up_rdata = '0;
      s0_up_rreq = 1'b0;
      checks++;
      if ({s0_up_rack, s0_up_rdata} !== {1'b1, 32'hA5A5_0001}) begin
         $display("FAIL read_ack0: got rack=%b rdata=%h want 1 a5a50001", s0_up_rack, s0_up_rdata);
         errors++;
      end
      checks++;
      if ({s1_up_rack, s1_up_rdata, m_up_rreq} !== '0) begin
         $display("FAIL read_other: got rack1=%b rdata1=%h rreq=%b want all 0",
                  s1_up_rack, s1_up_rdata, m_up_rreq);
         errors++;
      end
      tick();                                     // cycle 3
      checks++;
      if ({s0_up_rack, s0_up_rdata} !== '0) begin
         $display("FAIL read_after: got rack=%b rdata=%h want 0 0", s0_up_rack, s0_up_rdata);
         errors++;
      end
      $display("txn single read addr=00000004");
   endtask

   // -------------------------------------------------------------------------
   task automatic test_concurrent();
      s0_up_waddr = 32'h10; s0_up_wdata = 32'h55; s0_up_wreq = 1'b1;
      s1_up_raddr = 32'h20; s1_up_rreq = 1'b1;
      tick();                                     // cycle 1
      checks++;
      if ({m_up_wreq, m_up_rreq, m_up_waddr, m_up_wdata, m_up_raddr} !==
          {1'b1, 1'b1, 32'h10, 32'h55, 32'h20}) begin
         $display("FAIL conc_req: got wreq=%b rreq=%b waddr=%h wdata=%h raddr=%h",
                  m_up_wreq, m_up_rreq, m_up_waddr, m_up_wdata, m_up_raddr);
         errors++;
      end
      m_up_wack  = 1'b1;
      m_up_rack  = 1'b1;
      m_up_rdata = 32'h1234_5678;
      tick();                                     // cycle 2
      m_up_wack = 1'b0; m_up_rack = 1'b0; m_up_rdata = '0;
      s0_up_wreq = 1'b0; s1_up_rreq = 1'b0;
      checks++;
      if ({s0_up_wack, s1_up_wack, s0_up_rack, s1_up_rack} !== 4'b1001) begin
         $display("FAIL conc_route: got wack0=%b wack1=%b rack0=%b rack1=%b want 1 0 0 1",
                  s0_up_wack, s1_up_wack, s0_up_rack, s1_up_rack);
         errors++;
      end
      checks++;
      if ({s1_up_rdata, s0_up_rdata} !== {32'h1234_5678, 32'h0}) begin
         $display("FAIL conc_rdata: got rdata1=%h rdata0=%h want 12345678 00000000",
                  s1_up_rdata, s0_up_rdata);
         errors++;
      end
      tick();
      $display("txn concurrent write s0 + read s1");
   endtask

   // -------------------------------------------------------------------------
   task automatic test_timeout();
      m_up_rdata  = 32'hDEAD_BEEF;                // must not reach the requester
      s1_up_raddr = 32'h30;
      s1_up_rreq  = 1'b1;
      for (int c = 1; c <= TO; c++) begin
         tick();
         checks++;
         if ({m_up_rreq, s1_up_rack, timeout} !== 3'b100) begin
            $display("FAIL to_wait%0d: got rreq=%b rack1=%b timeout=%b want 1 0 0",
                     c, m_up_rreq, s1_up_rack, timeout);
            errors++;
         end
      end
      tick();                                     // cycle TO+1
      s1_up_rreq = 1'b0;
      checks++;
      if ({m_up_rreq, s1_up_rack, s1_up_rdata, timeout} !== {1'b0, 1'b1, 32'h0, 1'b1}) begin
         $display("FAIL to_fire: got rreq=%b rack1=%b rdata1=%h timeout=%b want 0 1 0 1",
                  m_up_rreq, s1_up_rack, s1_up_rdata, timeout);
         errors++;
      end
      m_up_rack = 1'b1;                           // late acknowledge
      tick();
      m_up_rack  = 1'b0;
      m_up_rdata = '0;
      tick();
      checks++;
      if ({m_up_rreq, s0_up_rack, s1_up_rack, timeout} !== 4'b0000) begin
         $display("FAIL to_late_ack: got rreq=%b rack0=%b rack1=%b timeout=%b want 0000",
                  m_up_rreq, s0_up_rack, s1_up_rack, timeout);
         errors++;
      end
      $display("txn timeout read s1 addr=00000030");
   endtask

   // -------------------------------------------------------------------------
   task automatic test_wait_state();
      s0_up_raddr = 32'h44;
      s0_up_rreq  = 1'b1;
      tick();                                     // cycle 1: rreq rises
      for (int c = 1; c <= 6; c++) begin
         checks++;
         if ({m_up_rreq, m_up_raddr, s0_up_rack, timeout} !== {1'b1, 32'h44, 1'b0, 1'b0}) begin
            $display("FAIL wait_hold%0d: got rreq=%b addr=%h rack0=%b timeout=%b",
                     c, m_up_rreq, m_up_raddr, s0_up_rack, timeout);
            errors++;
         end
         if (c < 6) tick();
      end
      m_up_rack  = 1'b1;                          // cycle 6: 5 cycles after rise
      m_up_rdata = 32'hCAFE_F00D;
      tick();                                     // cycle 7
      m_up_rack = 1'b0; m_up_rdata = '0; s0_up_rreq = 1'b0;
      checks++;
      if ({s0_up_rack, s0_up_rdata, m_up_rreq} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
         $display("FAIL wait_ack: got rack0=%b rdata0=%h rreq=%b want 1 cafef00d 0",
                  s0_up_rack, s0_up_rdata, m_up_rreq);
         errors++;
      end
      tick();
      $display("txn wait-state read s0 addr=00000044");
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset_mid();
      s0_up_waddr = 32'h60; s0_up_wdata = 32'h77; s0_up_wreq = 1'b1;
      tick();                                     // cycle 1
      checks++;
      if ({m_up_wreq, m_up_waddr} !== {1'b1, 32'h60}) begin
         $display("FAIL rmid_grant: got wreq=%b addr=%h want 1 00000060", m_up_wreq, m_up_waddr);
         errors++;
      end
      tick();                                     // cycle 2
      tick();                                     // cycle 3
      rst = 1'b1;
      tick();                                     // cycle 4
      checks++;
      if (outs !== '0) begin
         $display("FAIL rmid_outputs: got %h want 0", outs);
         errors++;
      end
      rst = 1'b0;
      s1_up_waddr = 32'h68; s1_up_wdata = 32'h88; s1_up_wreq = 1'b1;
      tick();                                     // cycle 5: tie after reset
      checks++;
      if ({m_up_wreq, m_up_waddr, m_up_wdata, s0_up_wack, s1_up_wack} !==
          {1'b1, 32'h60, 32'h77, 1'b0, 1'b0}) begin
         $display("FAIL rmid_tie: got wreq=%b addr=%h data=%h wack0=%b wack1=%b want 1 60 77 0 0",
                  m_up_wreq, m_up_waddr, m_up_wdata, s0_up_wack, s1_up_wack);
         errors++;
      end
      m_up_wack = 1'b1;
      tick();                                     // cycle 6
      m_up_wack = 1'b0; s0_up_wreq = 1'b0; s1_up_wreq = 1'b0;
      checks++;
      if ({s0_up_wack, s1_up_wack} !== 2'b10) begin
         $display("FAIL rmid_ack: got wack0=%b wack1=%b want 1 0", s0_up_wack, s1_up_wack);
         errors++;
      end
      tick();
      tick();
      $display("txn reset mid-transaction, then tie to s0");
   endtask

   // -------------------------------------------------------------------------
   initial begin
      rst = 1'b1;
      s0_up_rreq = 1'b0; s1_up_rreq = 1'b0; s0_up_wreq = 1'b0; s1_up_wreq = 1'b0;
      s0_up_raddr = '0; s1_up_raddr = '0; s0_up_waddr = '0; s1_up_waddr = '0;
      s0_up_wdata = '0; s1_up_wdata = '0;
      m_up_rack = 1'b0; m_up_wack = 1'b0; m_up_rdata = '0;

      test_reset();
      test_tie();
      test_single_read();
      test_concurrent();
      test_timeout();
      test_wait_state();
      test_reset_mid();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/up_arbiter_2to1.md
# up_arbiter_2to1

Two-requester round-robin arbiter for the uP register bus (rreq/rack/raddr/rdata, wreq/wack/waddr/wdata). It shares one uP slave, typically the GPIO register block, between two masters, e.g. the Wishbone bridge and a hardware sequencer. Read and write channels are arbitrated independently. Each channel has a watchdog, so a dead slave cannot hang a requester.

## Interface
- ADDRESS_WIDTH, 32, uP address width
- BUS_WIDTH, 4, data width in bytes (data = BUS_WIDTH*8 bits)
- TIMEOUT_CYCLES, 256, cycles in REQ before forced completion; 0 disables the watchdog
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- sN_up_rreq  in  1  read request from requester N (N = 0,1); level, held until its rack
- sN_up_raddr  in  ADDRESS_WIDTH  read address; stable while rreq high
- sN_up_rack  out  1  one-cycle read acknowledge to requester N
- sN_up_rdata  out  BUS_WIDTH*8  read data; valid only while sN_up_rack high, else 0
- sN_up_wreq  in  1  write request; level, held until its wack
- sN_up_waddr  in  ADDRESS_WIDTH  write address; stable while wreq high
- sN_up_wdata  in  BUS_WIDTH*8  write data; stable while wreq high
- sN_up_wack  out  1  one-cycle write acknowledge
- m_up_rreq  out  1  read request to slave
- m_up_raddr  out  ADDRESS_WIDTH  registered read address
- m_up_rack  in  1  slave read acknowledge
- m_up_rdata  in  BUS_WIDTH*8  slave read data, sampled when m_up_rack high
- m_up_wreq  out  1  write request to slave
- m_up_waddr  out  ADDRESS_WIDTH  registered write address
- m_up_wdata  out  BUS_WIDTH*8  registered write data
- m_up_wack  in  1  slave write acknowledge
- timeout  out  1  one-cycle pulse when either channel's watchdog fires

## Operation
- Read and write channels each run an identical FSM with states IDLE, REQ and DONE, plus a last-grant bit and a watchdog counter.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester that is not the last-grant bit.
  - On grant, latch the granted requester's address (and data for writes) into the m_ registers, set last-grant, clear the counter, and go to REQ.
- REQ:
  - m_ req is held high; the counter increments each cycle.
  - When m_ ack is high, capture m_ rdata (read channel) and go to DONE.
  - If instead the counter reaches TIMEOUT_CYCLES-1, go to DONE with captured rdata = 0 and pulse `timeout`.
- DONE (exactly one cycle):
  - m_ req is low.
  - The granted requester's sN ack is high, with sN_up_rdata = captured data; the other requester sees ack=0 and rdata=0.
  - Next state is always IDLE.
- Requests are ignored in REQ and DONE. A requester dropping its request before its ack is a protocol violation; the transaction still completes to the slave.
- A requester that keeps its request high after its ack starts a new transaction. Round-robin alternates grants whenever both requesters are requesting.
- m_ req is low for at least one cycle (DONE) between consecutive slave transactions.
- A slave ack seen outside REQ is ignored; a late ack after a timeout is dropped.
- Read and write channels may be in REQ simultaneously, even for the same requester.
- If `timeout` would fire on both channels in the same cycle, it is a single pulse.

## Timing
- Reset values:
  - All m_ and sN outputs = 0; `timeout` = 0.
  - Both FSMs in IDLE; counters 0.
  - Last-grant = 1, so requester 0 wins the first tie.
- Reset asserted mid-transaction returns both FSMs to IDLE the next cycle. Outputs go to reset values. No ack is issued for the aborted transaction.
- Latency, request sampled in IDLE at cycle 0:
  - m_ req rises in cycle 1.
  - Slave ack in cycle k (k ≥ 1) gives sN ack in cycle k+1.
  - Minimum round trip: sN ack in cycle 2.
- Timeout: m_ req is high for TIMEOUT_CYCLES cycles, cycles 1..TIMEOUT_CYCLES. sN ack and `timeout` are both high in cycle TIMEOUT_CYCLES+1.
- Back-to-back throughput per channel with a zero-wait slave is one transaction every 3 cycles.

## Test plan
- Single read: s0 rreq, raddr=0x4, slave acks in the first REQ cycle with rdata=0xA5A5_0001. Required: m_up_raddr=0x4; s0_up_rack in cycle 2 with rdata=0xA5A5_0001; s1 rack=0, rdata=0.
- Tie after reset: s0 and s1 wreq asserted in the same cycle (s0 waddr=0x0, wdata=0x1; s1 waddr=0x8, wdata=0x2), both held. Required grant order is s0, s1, s0, s1 on m_up_waddr. Each m_up_wreq burst is separated by one low cycle.
- Concurrent channels: s0 wreq and s1 rreq in the same cycle. Required: m_up_wreq and m_up_rreq both high in cycle 1; each ack routed only to its own requester.
- Timeout: TIMEOUT_CYCLES=8, s1 rreq, slave never acks. Required: m_up_rreq high cycles 1–8; s1_up_rack, rdata=0 and `timeout` high in cycle 9. A later slave rack is ignored.
- Reset mid-REQ: s0 wreq granted, rst asserted in cycle 3. Required: in cycle 4 all outputs are 0 and no wack is issued. After reset release, a new s1 request is granted first when tied with s0? No: after reset release, a tie is granted to s0.
- Wait-state slave: slave rack 5 cycles after m_up_rreq rises. Required: m_up_raddr stable throughout; s0 rack exactly one cycle after the slave rack.
